// File: rtl/avmm_poll_pkg.sv
// Shared types and legal parameter ranges for the Avalon-MM PIO poller.
package avmm_poll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_LAT  = 2'd2,
        ST_CMP  = 2'd3
    } poll_state_t;

    localparam int POLL_INTERVAL_MIN = 1;
    localparam int POLL_INTERVAL_MAX = 1 << 20;
    localparam int READ_LATENCY_MIN  = 1;
    localparam int READ_LATENCY_MAX  = 4;

    // The interval counter holds at most POLL_INTERVAL_MAX-1; the latency counter at most 3.
    localparam int INTERVAL_CNT_W = 20;
    localparam int LATENCY_CNT_W  = 2;

    // True when any bit selected by mask differs between a and b.
    function automatic logic masked_change(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] mask);
        return ((a ^ b) & mask) != 32'h0;
    endfunction

endpackage

// File: rtl/avmm_poll_evt_reg.sv
// Change-event holding register: valid/ready handshake, latest-wins overwrite, sticky overrun.
module avmm_poll_evt_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_raise,
    input  logic [31:0] i_data,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [31:0] o_data,
    output logic        o_overrun
);

    logic        r_valid;
    logic [31:0] r_data;
    logic        r_overrun;

    // A new event always loads; it only counts as an overrun if the old one was not taken this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_data    <= 32'h0;
            r_overrun <= 1'b0;
        end else if (i_raise) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            if (r_valid && !i_ready) begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid   = r_valid;
    assign o_data    = r_data;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/avmm_pio_poll_master.sv
// Periodic Avalon-MM reader that samples one register and raises an event on masked change.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | interval countdown (only while enable), then latch address
// READ    | avm_read asserted, waiting for waitrequest low
// LAT     | counting fixed readdata latency, sample on last cycle
// CMP     | update cur_data, raise event on change, reload interval
module avmm_pio_poll_master
    import avmm_poll_pkg::*;
#(
    parameter int          POLL_INTERVAL = 1000,
    parameter int          READ_LATENCY  = 1,
    parameter int          ADDR_W        = 2,
    parameter logic [31:0] CMP_MASK      = 32'h0000_0001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] poll_addr,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic [31:0]       cur_data,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [31:0]       evt_data,
    output logic              overrun,
    output logic              busy
);

    // Out-of-range parameters are clamped so the counters can never wrap.
    localparam int P_EFF = (POLL_INTERVAL < POLL_INTERVAL_MIN) ? POLL_INTERVAL_MIN :
                           (POLL_INTERVAL > POLL_INTERVAL_MAX) ? POLL_INTERVAL_MAX : POLL_INTERVAL;
    localparam int L_EFF = (READ_LATENCY < READ_LATENCY_MIN) ? READ_LATENCY_MIN :
                           (READ_LATENCY > READ_LATENCY_MAX) ? READ_LATENCY_MAX : READ_LATENCY;
    localparam logic [INTERVAL_CNT_W-1:0] INTERVAL_RELOAD = INTERVAL_CNT_W'(P_EFF - 1);
    localparam logic [LATENCY_CNT_W-1:0]  LATENCY_RELOAD  = LATENCY_CNT_W'(L_EFF - 1);

    poll_state_t               r_state;
    poll_state_t               w_next_state;
    logic [INTERVAL_CNT_W-1:0] r_interval_cnt;
    logic [LATENCY_CNT_W-1:0]  r_lat_cnt;
    logic [ADDR_W-1:0]         r_addr;
    logic [31:0]               r_sample;
    logic [31:0]               r_cur_data;
    logic                      r_baseline;
    logic                      w_evt_raise;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; enable is only consulted in IDLE so an issued read always completes.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (enable && (r_interval_cnt == '0)) w_next_state = ST_READ;
            ST_READ: if (!avm_waitrequest)                 w_next_state = ST_LAT;
            ST_LAT:  if (r_lat_cnt == '0)                  w_next_state = ST_CMP;
            ST_CMP:                                        w_next_state = ST_IDLE;
            default:                                       w_next_state = ST_IDLE;
        endcase
    end

    // Counters, address latch, readdata sample and the compare baseline.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_interval_cnt <= INTERVAL_RELOAD;
            r_lat_cnt      <= '0;
            r_addr         <= '0;
            r_sample       <= 32'h0;
            r_cur_data     <= 32'h0;
            r_baseline     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        if (r_interval_cnt == '0) begin
                            r_addr <= poll_addr;
                        end else begin
                            r_interval_cnt <= r_interval_cnt - 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (!avm_waitrequest) begin
                        r_lat_cnt <= LATENCY_RELOAD;
                    end
                end
                ST_LAT: begin
                    if (r_lat_cnt == '0) begin
                        r_sample <= avm_readdata;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end
                ST_CMP: begin
                    r_cur_data     <= r_sample;
                    r_baseline     <= 1'b1;
                    r_interval_cnt <= INTERVAL_RELOAD;
                end
                default: ;
            endcase
        end
    end

    // The very first sample only establishes the baseline.
    assign w_evt_raise = (r_state == ST_CMP) && r_baseline &&
                         masked_change(r_sample, r_cur_data, CMP_MASK);

    avmm_poll_evt_reg u_evt_reg (
        .clk       (clk),
        .reset     (reset),
        .i_raise   (w_evt_raise),
        .i_data    (r_sample),
        .i_ready   (evt_ready),
        .o_valid   (evt_valid),
        .o_data    (evt_data),
        .o_overrun (overrun)
    );

    assign avm_read    = (r_state == ST_READ);
    assign busy        = (r_state == ST_READ) || (r_state == ST_LAT);
    assign avm_address = r_addr;
    assign cur_data    = r_cur_data;

endmodule

// File: doc/avmm_pio_poll_master.md
AVMM_PIO_POLL_MASTER -- requirements
Module: avmm_pio_poll_master

Interface
REQ-001 SHALL have parameter POLL_INTERVAL, default 1000, meaning cycles from the end of one poll to the next read request (legal range 1 to 2^20).
REQ-002 SHALL have parameter READ_LATENCY, default 1, meaning the slave's fixed readdata latency in cycles after read acceptance (legal range 1 to 4).
REQ-003 SHALL have parameter ADDR_W, default 2, meaning address width.
REQ-004 SHALL have parameter CMP_MASK, default 32'h0000_0001, meaning which readdata bits are compared for change.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; one clock domain, all logic on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1 bit: polling permitted.
REQ-008 SHALL have port poll_addr, input, ADDR_W bits: register address to poll, sampled when a read is issued.
REQ-009 SHALL have port avm_address, output, ADDR_W bits: Avalon-MM master address.
REQ-010 SHALL have port avm_read, output, 1 bit: Avalon-MM read request.
REQ-011 SHALL have port avm_waitrequest, input, 1 bit: slave stall.
REQ-012 SHALL have port avm_readdata, input, 32 bits: slave read data.
REQ-013 SHALL have port cur_data, output, 32 bits: last sampled full readdata.
REQ-014 SHALL have port evt_valid, output, 1 bit: change event pending.
REQ-015 SHALL have port evt_ready, input, 1 bit: consumer accepts the event.
REQ-016 SHALL have port evt_data, output, 32 bits: readdata that caused the event.
REQ-017 SHALL have port overrun, output, 1 bit: sticky flag, an event was overwritten before it was accepted.
REQ-018 SHALL have port busy, output, 1 bit: high in states READ and LAT.

Function
REQ-019 SHALL implement an FSM with states IDLE, READ, LAT, CMP.
REQ-020 IDLE: the interval counter decrements while enable=1 and holds while enable=0; on reaching 0 with enable=1, the FSM latches poll_addr and goes to READ.
REQ-021 READ: avm_read=1 and avm_address is held stable; the read is accepted in the first cycle with avm_waitrequest=0, after which the FSM goes to LAT.
REQ-022 LAT: counts READ_LATENCY cycles; avm_readdata is sampled exactly READ_LATENCY cycles after the acceptance cycle, then the FSM goes to CMP.
REQ-023 CMP: cur_data is updated with the sample; the FSM reloads the counter with POLL_INTERVAL-1 and returns to IDLE; CMP lasts one cycle.
REQ-024 In CMP, an event is raised when (sample XOR previous cur_data) AND CMP_MASK is nonzero.
REQ-025 The first sample after reset is the baseline only and SHALL raise no event.
REQ-026 When an event is raised, evt_data is loaded with the sample and evt_valid=1 from the next cycle.
REQ-027 evt_valid SHALL clear on the cycle after evt_valid and evt_ready are both high.
REQ-028 evt_valid and evt_data SHALL stay stable until accepted, except as stated in REQ-029.
REQ-029 If an event is raised while evt_valid=1 and evt_ready=0, evt_data is overwritten (latest wins), evt_valid stays 1 and overrun is set.
REQ-030 If an event is raised in the same cycle as an accept, the new event is loaded, evt_valid stays 1, and overrun is not set.
REQ-031 Deasserting enable in READ or LAT SHALL NOT abort the transaction; it completes through CMP, then the FSM waits in IDLE.
REQ-032 avm_read SHALL be 1 only in READ; no second read is outstanding.

Reset
REQ-033 On reset=1 at a clock edge: state=IDLE, counter=POLL_INTERVAL-1, avm_read=0, avm_address=0, cur_data=0, evt_data=0, evt_valid=0, overrun=0, busy=0, baseline flag cleared.
REQ-034 Reset mid-transaction SHALL drop avm_read in the cycle following the reset edge and discard any pending readdata.

Structure
REQ-035 The FSM state enum and READ_LATENCY/POLL_INTERVAL range constants SHALL live in shared package avmm_poll_pkg.
REQ-036 The event holding register and its valid/ready/overrun logic SHALL be sub-module avmm_poll_evt_reg; the FSM, counters and Avalon logic stay in the top module.

Verification
REQ-037 POLL_INTERVAL=4, waitrequest=0, readdata=0, then 1 after the first poll -> first read raises no event; second sample raises evt_valid with evt_data=32'h1 and cur_data=1.
REQ-038 waitrequest held high for 3 cycles -> avm_read and avm_address stable for 4 cycles; readdata sampled exactly READ_LATENCY cycles after the acceptance cycle.
REQ-039 readdata toggles 0->1->0 with evt_ready=0 -> evt_data=0, overrun=1, evt_valid=1; evt_ready=1 for one cycle -> evt_valid=0 next cycle.
REQ-040 readdata changes 32'h0 -> 32'h2 (outside CMP_MASK) -> no event, cur_data=32'h2.
REQ-041 enable dropped in READ -> read completes, cur_data updated, no further avm_read until enable returns.
REQ-042 reset asserted in LAT -> all outputs equal their REQ-033 values, and the next sample after reset raises no event.
